// File: rtl/pcm_to_i2s_converter.sv
// -----------------------------------------------------------------------------
// pcm_to_i2s_converter
//
// Stereo Philips-I2S master transmitter. bclk and lrclk are derived from the
// system clock. Incoming per-channel PCM words are held in a pending buffer
// and copied into the active (transmitting) pair only when a left slot starts.
// Both words of a frame therefore always come from the same L+R pair.
//
// Optional feature (compile-time macro MUTE_ON_UNDERRUN_EN):
//   defined   : a frame that starts without a complete new pair sends silence
//   undefined : a frame that starts without a complete new pair repeats the
//               previous pair
//
// Parameters:
//   num_of_sample_bits  PCM word width N
//   bits_per_channel    bclk periods per channel slot (>= N+1)
//   bclk_div            clk cycles per bclk half-period (>= 1)
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset
//   l_din_valid  strobe: l_pcm_data is valid this cycle
//   r_din_valid  strobe: r_pcm_data is valid this cycle
//   l_pcm_data   left sample, two's complement
//   r_pcm_data   right sample, two's complement
//   bclk_out     I2S bit clock
//   lrclk_out    I2S word select (0 = left)
//   i2s_dout     serial data, changes only when bclk falls
//   frame_start  one-clk strobe when a left slot begins
//   underrun     one-clk strobe when a frame starts without a new L+R pair
//   overrun      one-clk strobe when a pending sample is overwritten
// -----------------------------------------------------------------------------
module pcm_to_i2s_converter #(
   parameter int num_of_sample_bits = 24,
   parameter int bits_per_channel   = 32,
   parameter int bclk_div           = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          l_din_valid,
   input  logic                          r_din_valid,
   input  logic [num_of_sample_bits-1:0] l_pcm_data,
   input  logic [num_of_sample_bits-1:0] r_pcm_data,
   output logic                          bclk_out,
   output logic                          lrclk_out,
   output logic                          i2s_dout,
   output logic                          frame_start,
   output logic                          underrun,
   output logic                          overrun
);

   localparam int N      = num_of_sample_bits;
   localparam int DIV_W  = (bclk_div > 1) ? $clog2(bclk_div) : 1;
   localparam int SLOT_W = $clog2(bits_per_channel);
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(bclk_div - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(bits_per_channel - 1);

   // Registered state
   logic [DIV_W-1:0]  div_cnt;
   logic [SLOT_W-1:0] slot_pos;
   logic              pend_l;
   logic              pend_r;
   logic [N-1:0]      pend_word_l;
   logic [N-1:0]      pend_word_r;
   logic [N-1:0]      active_l;
   logic [N-1:0]      active_r;

   // Combinational decode
   logic              tick;        // bclk toggles on this clk edge
   logic              fall_edge;   // bclk goes 1->0 on this clk edge
   logic              slot_wrap;   // slot_pos wraps to 0 on this clk edge
   logic              frame_load;  // left slot begins on this clk edge
   logic              pair_ready;
   logic [SLOT_W-1:0] slot_next;
   logic              lrclk_next;
   logic [N-1:0]      tx_word;
   logic [IDX_W-1:0]  bit_idx;
   logic              data_bit;
   logic              ovr_l;
   logic              ovr_r;

   // NOTE: every signal gets a default at the top of always_comb so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      tick       = (div_cnt == DIV_LAST);
      fall_edge  = tick && bclk_out;
      slot_wrap  = fall_edge && (slot_pos == SLOT_LAST);
      frame_load = slot_wrap && lrclk_out;
      pair_ready = pend_l && pend_r;

      slot_next  = (slot_pos == SLOT_LAST) ? '0 : slot_pos + 1'b1;
      lrclk_next = slot_wrap ? ~lrclk_out : lrclk_out;

      // The bit sent is chosen by the slot position and channel that are
      // about to be presented, so the MSB lands one bclk after lrclk changes.
      tx_word  = lrclk_next ? active_r : active_l;
      bit_idx  = IDX_W'(N - int'(slot_next));
      data_bit = 1'b0;
      if ((slot_next != '0) && (int'(slot_next) <= N)) begin
         data_bit = tx_word[bit_idx];
      end

      // A strobe only overruns if the pending flag survives this edge; a
      // simultaneous frame load consumes the old word first.
      ovr_l = l_din_valid && pend_l && !(frame_load && pair_ready);
      ovr_r = r_din_valid && pend_r && !(frame_load && pair_ready);
   end

   // NOTE: all registered state uses non-blocking assignments so every read
   // in this block sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt     <= '0;
         bclk_out    <= 1'b0;
         slot_pos    <= SLOT_LAST;
         lrclk_out   <= 1'b1;
         i2s_dout    <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         overrun     <= 1'b0;
         pend_l      <= 1'b0;
         pend_r      <= 1'b0;
         pend_word_l <= '0;
         pend_word_r <= '0;
         active_l    <= '0;
         active_r    <= '0;
      end else begin
         // bclk divider
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            bclk_out <= ~bclk_out;
         end

         // Slot counter, word select and serial data all move on bclk fall
         if (fall_edge) begin
            slot_pos  <= slot_next;
            lrclk_out <= lrclk_next;
            i2s_dout  <= data_bit;
         end

         frame_start <= frame_load;
         underrun    <= frame_load && !pair_ready;
         overrun     <= ovr_l || ovr_r;

         // Pending buffer: a new strobe always wins over the clear from a
         // frame load, so a sample arriving on the load edge goes out next.
         pend_l <= l_din_valid || (pend_l && !(frame_load && pair_ready));
         pend_r <= r_din_valid || (pend_r && !(frame_load && pair_ready));
         if (l_din_valid) begin
            pend_word_l <= l_pcm_data;
         end
         if (r_din_valid) begin
            pend_word_r <= r_pcm_data;
         end

         // Active pair changes only at the start of a left slot
         if (frame_load && pair_ready) begin
            active_l <= pend_word_l;
            active_r <= pend_word_r;
         end
`ifdef MUTE_ON_UNDERRUN_EN
         else if (frame_load) begin
            active_l <= '0;
            active_r <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_pcm_to_i2s_converter.sv
`timescale 1ns/1ps
module tb_pcm_to_i2s_converter;

   localparam int N      = 24;
   localparam int SLOT   = 32;
   localparam int DIV2   = 2;
   localparam int FRAME2 = 2 * SLOT * 2 * DIV2;   // 256 clk per frame at bclk_div=2
   localparam int NF     = 6;

   function automatic int load_edge(input int k);
      return 2 * DIV2 + k * FRAME2;
   endfunction

   // ---------------------------------------------------------------- clocking
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   // Main DUT (bclk_div = 2)
   logic         l_valid, r_valid;
   logic [N-1:0] l_data, r_data;
   logic         bclk, lrclk, dout, fs, ur, ov;

   // Default-parameter DUT with idle inputs
   logic         idle_valid;
   logic [N-1:0] idle_data;
   logic         d_bclk, d_lrclk, d_dout, d_fs, d_ur, d_ov;

   pcm_to_i2s_converter #(
      .num_of_sample_bits(N),
      .bits_per_channel(SLOT),
      .bclk_div(DIV2)
   ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .l_din_valid(l_valid), .r_din_valid(r_valid),
      .l_pcm_data(l_data), .r_pcm_data(r_data),
      .bclk_out(bclk), .lrclk_out(lrclk), .i2s_dout(dout),
      .frame_start(fs), .underrun(ur), .overrun(ov)
   );

   pcm_to_i2s_converter u_dut_def (
      .clk(clk), .reset_n(reset_n),
      .l_din_valid(idle_valid), .r_din_valid(idle_valid),
      .l_pcm_data(idle_data), .r_pcm_data(idle_data),
      .bclk_out(d_bclk), .lrclk_out(d_lrclk), .i2s_dout(d_dout),
      .frame_start(d_fs), .underrun(d_ur), .overrun(d_ov)
   );

   // ---------------------------------------------------------------- checking
   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------- serial monitor on main DUT
   logic         mon_en    = 1'b0;
   logic         prev_bclk = 1'b0;
   logic         prev_lr   = 1'b1;
   int           fidx      = -1;
   int           pos       = 0;
   int           fs_seen   = 0;
   int           ov_seen   = 0;
   int           fs_miss   = 0;
   logic         lbits [SLOT];
   logic         rbits [SLOT];
   logic [N-1:0] rx_l  [NF];
   logic [N-1:0] rx_r  [NF];
   logic         rx_pad[NF];
   logic         rx_ur [NF];

   task automatic close_frame(input int k);
      logic [N-1:0] wl;
      logic [N-1:0] wr;
      logic         pad;
      pad = 1'b1;
      for (int p = 1; p <= N; p++) begin
         wl[N-p] = lbits[p];
         wr[N-p] = rbits[p];
      end
      for (int p = 0; p < SLOT; p++) begin
         if ((p == 0 || p > N) && (lbits[p] !== 1'b0 || rbits[p] !== 1'b0)) pad = 1'b0;
      end
      rx_l[k]   = wl;
      rx_r[k]   = wr;
      rx_pad[k] = pad;
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (fs) fs_seen++;
         if (ov) ov_seen++;
         if (prev_bclk && !bclk) begin
            if (prev_lr && !lrclk) begin
               if (fidx >= 0 && fidx < NF) close_frame(fidx);
               fidx++;
               if (!fs) fs_miss++;
               if (fidx < NF) rx_ur[fidx] = ur;
            end
            if (lrclk != prev_lr) pos = 0;
            else                  pos++;
            if (pos < SLOT) begin
               if (lrclk) rbits[pos] = dout;
               else       lbits[pos] = dout;
            end
         end
      end
      prev_bclk = bclk;
      prev_lr   = lrclk;
   end

   // ------------------------------------------------------------ stimulus
   int cyc = 0;   // clk edges since reset release, advanced only by main_phase

   task automatic step_to(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic strobe(input logic lv, input logic [N-1:0] ld,
                         input logic rv, input logic [N-1:0] rd);
      l_valid = lv;
      l_data  = ld;
      r_valid = rv;
      r_data  = rd;
      step_to(cyc + 1);
      l_valid = 1'b0;
      r_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bclk"},  {31'd0, bclk},  32'd0);
      check({tag, "_lrclk"}, {31'd0, lrclk}, 32'd1);
      check({tag, "_dout"},  {31'd0, dout},  32'd0);
      check({tag, "_fs"},    {31'd0, fs},    32'd0);
      check({tag, "_ur"},    {31'd0, ur},    32'd0);
      check({tag, "_ov"},    {31'd0, ov},    32'd0);
   endtask

   // Default-parameter DUT: free-running timing with no data
   task automatic default_phase();
      int e_bclk = 0, e_lr = 0, e_fs = 0, e_dout = 0;
      logic exp_lr, exp_fs;
      for (int k = 1; k <= 600; k++) begin
         @(posedge clk);
         #1;
         exp_lr = (k < 8) ? 1'b1 : ((((k - 8) / 256) % 2) != 0);
         exp_fs = (k == 8) || (k == 520);
         if (d_bclk !== (((k / 4) % 2) != 0)) e_bclk++;
         if (d_lrclk !== exp_lr) e_lr++;
         if (d_fs !== exp_fs || d_ur !== exp_fs) e_fs++;
         if (d_dout !== 1'b0 || d_ov !== 1'b0) e_dout++;
         if (k == 7) check("def_lr_before_first_fall", {31'd0, d_lrclk}, 32'd1);
         if (k == 8) begin
            check("def_lr_first_fall", {31'd0, d_lrclk}, 32'd0);
            check("def_first_underrun", {31'd0, d_ur}, 32'd1);
         end
      end
      check("def_bclk_pattern",  e_bclk, 0);
      check("def_lrclk_pattern", e_lr,   0);
      check("def_fs_ur_pattern", e_fs,   0);
      check("def_dout_silent",   e_dout, 0);
   endtask

   task automatic main_phase();
      logic [N-1:0] exp_l [5];
      logic [N-1:0] exp_r [5];
      logic         exp_ur[NF];
      int           e_bclk = 0, e_lr = 0, e_fs = 0, e_dout = 0;
      logic         exp_lr, exp_fs;

      exp_l[0] = 24'hA5A5A5; exp_r[0] = 24'h5A5A5A;
`ifdef MUTE_ON_UNDERRUN_EN
      exp_l[1] = 24'h000000; exp_r[1] = 24'h000000;
`else
      exp_l[1] = 24'hA5A5A5; exp_r[1] = 24'h5A5A5A;
`endif
      exp_l[2] = 24'h222222; exp_r[2] = 24'h333333;
      exp_l[3] = 24'h0F0F0F; exp_r[3] = 24'hF0F0F0;
      exp_l[4] = 24'h7FFFFF; exp_r[4] = 24'h800000;
      exp_ur   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      // First pair before the first left slot (sampled at edge 1)
      strobe(1'b1, 24'hA5A5A5, 1'b1, 24'h5A5A5A);

      // Frame 1 gets no new pair; during it, overwrite the left sample once
      step_to(299);
      strobe(1'b1, 24'h111111, 1'b0, 24'h0);
      step_to(309);
      strobe(1'b1, 24'h222222, 1'b1, 24'h333333);
      check("overrun_pulse", {31'd0, ov}, 32'd1);
      step_to(cyc + 1);
      check("overrun_one_clk", {31'd0, ov}, 32'd0);

      // Older pair pending, then a new pair on the exact frame-load edge
      step_to(599);
      strobe(1'b1, 24'h0F0F0F, 1'b1, 24'hF0F0F0);
      step_to(load_edge(3) - 1);
      strobe(1'b1, 24'h7FFFFF, 1'b1, 24'h800000);
      check("load_edge_frame_start", {31'd0, fs}, 32'd1);
      check("load_edge_no_overrun",  {31'd0, ov}, 32'd0);

      step_to(load_edge(5) + 16);
      check("frames_started", fidx, NF - 1);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("frame%0d_left", k),    {8'd0, rx_l[k]}, {8'd0, exp_l[k]});
         check($sformatf("frame%0d_right", k),   {8'd0, rx_r[k]}, {8'd0, exp_r[k]});
         check($sformatf("frame%0d_padding", k), {31'd0, rx_pad[k]}, 32'd1);
      end
      for (int k = 0; k < NF; k++) begin
         check($sformatf("frame%0d_underrun", k), {31'd0, rx_ur[k]}, {31'd0, exp_ur[k]});
      end
      check("fs_at_every_lr_fall", fs_miss, 0);
      check("fs_pulse_count",      fs_seen, NF);
      check("overrun_cycles",      ov_seen, 1);

      // Reset in the right slot of frame 5 at p=10, while bclk is high
      mon_en = 1'b0;
      step_to(load_edge(5) + FRAME2 / 2 + 10 * 2 * DIV2 + DIV2);
      check("pre_reset_bclk_high", {31'd0, bclk},  32'd1);
      check("pre_reset_right",     {31'd0, lrclk}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("midrst_hold");
      reset_n = 1'b1;

      // Timing restarts exactly as from the first release, no stale data
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         exp_lr = (k < 4) ? 1'b1 : ((((k - 4) / 128) % 2) != 0);
         exp_fs = (k == 4) || (k == 260);
         if (bclk !== (((k / 2) % 2) != 0)) e_bclk++;
         if (lrclk !== exp_lr) e_lr++;
         if (fs !== exp_fs || ur !== exp_fs) e_fs++;
         if (dout !== 1'b0 || ov !== 1'b0) e_dout++;
      end
      check("restart_bclk_pattern",  e_bclk, 0);
      check("restart_lrclk_pattern", e_lr,   0);
      check("restart_fs_ur_pattern", e_fs,   0);
      check("restart_dout_silent",   e_dout, 0);
   endtask

   initial begin
      reset_n    = 1'b0;
      l_valid    = 1'b0;
      r_valid    = 1'b0;
      l_data     = '0;
      r_data     = '0;
      idle_valid = 1'b0;
      idle_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      check("reset_def_lrclk", {31'd0, d_lrclk}, 32'd1);
      check("reset_def_bclk",  {31'd0, d_bclk},  32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      mon_en  = 1'b1;
      fork
         default_phase();
         main_phase();
      join
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
      $fatal(1, "watchdog expired");
   end

endmodule
